// File: rtl/mem_pkg.sv
// mem_pkg: state encoding, word size and counter width shared by mem_slave
package mem_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, ACK, RELEASE} state_t;
  localparam int MEM_WORD_BYTES = 4;
  localparam int MEM_CNT_W = 16;
endpackage

// File: rtl/sp_ram.sv
// sp_ram: synchronous single-port RAM (clk, we, addr, wdata in; registered rdata out), no reset
module sp_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_slave.sv
// mem_slave: wait-stated word RAM target (clk, reset, mem_read/mem_write/mem_addr/mem_write_data in; mem_ack/mem_error/mem_read_data, rd_count/wr_count out)
module mem_slave import mem_pkg::*; #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_write_data,
  output logic                 mem_ack,
  output logic                 mem_error,
  output logic [31:0]          mem_read_data,
  output logic [MEM_CNT_W-1:0] rd_count,
  output logic [MEM_CNT_W-1:0] wr_count
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic rd_q, wr_q, err_q, bad, we, req;
  logic [31:0] addr_q, wdata_q, off, ram_rdata;
  assign req = mem_read | mem_write;
  assign off = addr_q - BASE_ADDR;
  assign bad = (rd_q & wr_q) | (off[1:0] != 2'b00) | (off[31:ADDR_WIDTH+2] != '0);
  assign we = (state == ACCESS) & wr_q & ~bad;
  sp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .we(we),
    .addr(off[ADDR_WIDTH+1:2]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = (WS == 4'd0) ? ACCESS : WAIT;
      WAIT:    if (cnt <= 4'd1) state_nx = ACCESS;
      ACCESS:  state_nx = ACK;
      ACK:     state_nx = RELEASE;
      RELEASE: if (!req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      mem_ack <= 1'b0;
      mem_error <= 1'b0;
      mem_read_data <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      mem_ack <= state == ACK;
      mem_error <= (state == ACK) & err_q;
      if (state == IDLE && req) begin
        rd_q <= mem_read;
        wr_q <= mem_write;
        addr_q <= mem_addr;
        wdata_q <= mem_write_data;
        cnt <= WS;
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == ACCESS) err_q <= bad;
      if (state == ACK) begin
        mem_read_data <= err_q ? '0 : rd_q ? ram_rdata : mem_read_data;
        if (!err_q && rd_q && rd_count != '1) rd_count <= rd_count + MEM_CNT_W'(1);
        if (!err_q && wr_q && wr_count != '1) wr_count <= wr_count + MEM_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_slave.sv
// tb_mem_slave: randomized master against a transaction-level model of mem_slave
module tb_mem_slave;
  import mem_pkg::*;
  localparam int AW = 10;
  localparam int WS = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic clk = 1'b0, reset = 1'b1, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_addr = '0, mem_write_data = '0;
  logic mem_ack, mem_error;
  logic [31:0] mem_read_data;
  logic [MEM_CNT_W-1:0] rd_count, wr_count;
  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] mdl_mem [int];
  logic p_valid = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  int p_at = 0;
  logic [31:0] p_addr = '0, p_data = '0;
  logic [15:0] m_rd = '0, m_wr = '0;
  logic [31:0] m_rdata = '0;
  logic m_known = 1'b1, m_ack = 1'b0, m_err = 1'b0;
  mem_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_ack(mem_ack),
    .mem_error(mem_error),
    .mem_read_data(mem_read_data),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic bad_req(input logic rd, input logic wr, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (rd && wr) || (a % 4 != 0) || off < 0 || off >= 4 * (longint'(1) << AW);
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      p_valid = 1'b0;
      m_rd = '0;
      m_wr = '0;
      m_rdata = '0;
      m_known = 1'b1;
      chk("rst_ack", 32'(mem_ack), 0);
      chk("rst_error", 32'(mem_error), 0);
      chk("rst_read_data", mem_read_data, 0);
      chk("rst_rd_count", 32'(rd_count), 0);
      chk("rst_wr_count", 32'(wr_count), 0);
    end else begin
      m_ack = p_valid && cyc == p_at;
      m_err = 1'b0;
      if (m_ack) begin
        p_valid = 1'b0;
        m_err = bad_req(p_rd, p_wr, p_addr);
        if (m_err) begin
          m_rdata = '0;
          m_known = 1'b1;
        end else if (p_rd) begin
          m_known = mdl_mem.exists(widx(p_addr));
          if (m_known) m_rdata = mdl_mem[widx(p_addr)];
          if (m_rd != 16'hFFFF) m_rd++;
        end else begin
          mdl_mem[widx(p_addr)] = p_data;
          if (m_wr != 16'hFFFF) m_wr++;
        end
      end
      chk("ack", 32'(mem_ack), 32'(m_ack));
      if (m_ack) chk("error", 32'(mem_error), 32'(m_err));
      if (m_known) chk("read_data", mem_read_data, m_rdata);
      chk("rd_count", 32'(rd_count), 32'(m_rd));
      chk("wr_count", 32'(wr_count), 32'(m_wr));
    end
  end
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output int lat, output logic [31:0] rdat, output logic err);
    int e0;
    @(negedge clk);
    mem_read = rd;
    mem_write = wr;
    mem_addr = a;
    mem_write_data = d;
    e0 = cyc + 1;
    p_rd = rd;
    p_wr = wr;
    p_addr = a;
    p_data = d;
    p_at = e0 + WS + 2;
    p_valid = 1'b1;
    lat = -1;
    rdat = '0;
    err = 1'b0;
    @(posedge clk);
    #1 mem_addr = $urandom;
    mem_write_data = $urandom;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (mem_ack) begin
        lat = cyc - e0;
        rdat = mem_read_data;
        err = mem_error;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: addr %h got no ack required one within 40 cycles", a);
      p_valid = 1'b0;
    end
    repeat (hold) @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    logic [31:0] rdat;
    logic er;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      xact(1'b0, 1'b1, 32'(4 * k), 32'(4 * (k + 1)), k % 3, lat, rdat, er);
      if (k == 0) chk("first_wr_latency", 32'(lat), 4);
      xact(1'b1, 1'b0, 32'(4 * k), 32'h0, k % 2, lat, rdat, er);
      chk("pair_read", rdat, 32'(4 * (k + 1)));
      if (k == 0) begin
        chk("first_rd_latency", 32'(lat), 4);
        chk("first_rd_error", 32'(er), 0);
        chk("first_wr_count", 32'(wr_count), 1);
        chk("first_rd_count", 32'(rd_count), 1);
      end
    end
    chk("loop_wr_count", 32'(wr_count), 8);
    chk("loop_rd_count", 32'(rd_count), 8);
    xact(1'b1, 1'b0, 32'h0000_0002, 32'h0, 0, lat, rdat, er);
    chk("misaligned_error", 32'(er), 1);
    chk("misaligned_data", rdat, 0);
    xact(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1, lat, rdat, er);
    chk("range_error", 32'(er), 1);
    chk("range_data", rdat, 0);
    chk("err_rd_count", 32'(rd_count), 8);
    chk("err_wr_count", 32'(wr_count), 8);
    xact(1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 0, lat, rdat, er);
    chk("both_error", 32'(er), 1);
    xact(1'b1, 1'b0, 32'h0000_0008, 32'h0, 0, lat, rdat, er);
    chk("both_no_write", rdat, 32'h0000_000C);
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr = 32'h0000_000C;
    mem_write_data = 32'h1234_5678;
    @(negedge clk);
    #1 reset = 1'b1;
    mem_write = 1'b0;
    #1 chk("async_clear_count", 32'(wr_count), 0);
    chk("async_clear_data", mem_read_data, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    xact(1'b1, 1'b0, 32'h0000_000C, 32'h0, 0, lat, rdat, er);
    chk("reset_no_write", rdat, 32'h0000_0010);
    chk("post_reset_wr_count", 32'(wr_count), 0);
    for (int n = 0; n < 150; n++) begin
      int r, s;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      s = $urandom_range(0, 19);
      a = 32'(4 * $urandom_range(0, 63));
      if (s == 0) a = a + 32'($urandom_range(1, 3));
      if (s == 1) a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 1000));
      if (s == 2) a = $urandom;
      xact(r < 47 || r >= 94, r >= 47, a, $urandom, $urandom_range(0, 2), lat, rdat, er);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    @(posedge clk);
    #1 force dut.wr_count = 16'hFFFE;
    m_wr = 16'hFFFE;
    #1 release dut.wr_count;
    for (int k = 0; k < 3; k++) begin
      xact(1'b0, 1'b1, 32'(4 * k), 32'(k), 0, lat, rdat, er);
      chk("sat_wr_count", 32'(wr_count), 32'h0000_FFFF);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_slave.md
# mem_slave

Word-addressed on-chip memory target that sits directly downstream of the CPU memory master and answers its `mem_read`/`mem_write` requests with a one-cycle `mem_ack`. It inserts a programmable number of wait states, performs the access on an internal synchronous single-port RAM, and flags illegal requests with `mem_error`. It also keeps saturating read and write access counters for bring-up debug.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: RAM depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, default 2: idle cycles inserted between request capture and RAM access (0–15).
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be aligned to the RAM size.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `mem_read` input 1: read request, level, held by master until it samples ack.
- `mem_write` input 1: write request, level, same rules.
- `mem_addr` input 32: byte address, captured at request acceptance.
- `mem_write_data` input 32: write data, captured at request acceptance.
- `mem_ack` output 1: one-cycle completion pulse.
- `mem_error` output 1: valid only while `mem_ack`=1; 1 means the request was rejected.
- `mem_read_data` output 32: read result, valid while `mem_ack`=1 for reads; holds its value otherwise.
- `rd_count` output 16: successful reads, saturating.
- `wr_count` output 16: successful writes, saturating.

## Operation
- Reset values: `mem_ack`=0, `mem_error`=0, `mem_read_data`=0, `rd_count`=0, `wr_count`=0, state IDLE, wait counter 0.
- FSM states:
  - IDLE: if `mem_read`|`mem_write` at an edge, capture op, address, and data, then go to WAIT. If `WAIT_STATES`=0, go straight to ACCESS.
  - WAIT: load the counter with `WAIT_STATES`. Decrement once per cycle. When it reaches 1, go to ACCESS.
  - ACCESS: classify the captured request, then issue a RAM read or write, or nothing on error. Go to ACK.
  - ACK: drive `mem_ack`=1 for exactly one cycle, along with `mem_error` and `mem_read_data`. Go to RELEASE.
  - RELEASE: stay until `mem_read`=0 and `mem_write`=0 at an edge, then go to IDLE. This prevents a held request from being re-accepted.
- Error conditions, checked in ACCESS in priority order; any one sets `mem_error`=1:
  - both `mem_read` and `mem_write` were captured high;
  - `mem_addr[1:0]`≠0;
  - address outside [`BASE_ADDR`, `BASE_ADDR`+4·2^ADDR_WIDTH).
- On error: no RAM write, `mem_read_data`=0 during ack, no counter change.
- RAM word index is (`mem_addr`−`BASE_ADDR`)[ADDR_WIDTH+1:2].
- Counters:
  - `rd_count` increments on an error-free read ack; `wr_count` on an error-free write ack.
  - Both saturate at 16'hFFFF (no wrap).
- Write ack leaves `mem_read_data` unchanged.
- Request inputs are ignored outside IDLE and RELEASE. Input changes after capture do not affect the transaction in flight.

## Timing
- The request is sampled at edge E0 in IDLE.
- `mem_ack` is high in the cycle after edge E0+WAIT_STATES+2:
  - `WAIT_STATES`=0: ack is high after E2;
  - `WAIT_STATES`=2: ack is high after E4.
- RAM is synchronous: read data is registered at the ACCESS→ACK edge.
- Handshake: a master that drops its request on the edge it samples ack sees the slave leave RELEASE one edge later. A new request can then be accepted at the following edge.
- Minimum transaction spacing is WAIT_STATES+4 cycles.
- Reset mid-operation asserts asynchronously:
  - outputs clear immediately and the FSM returns to IDLE;
  - a write is committed only if the ACCESS edge completed before reset;
  - RAM contents are not cleared.

## Structure
- Package `mem_pkg` holds:
  - the state enum: IDLE, WAIT, ACCESS, ACK, RELEASE;
  - the constant `MEM_WORD_BYTES`=4;
  - the counter width constant `MEM_CNT_W`=16.
- Sub-module `sp_ram`: synchronous single-port RAM, parameterised by `ADDR_WIDTH`. Ports are `clk`, `we`, `addr`, `wdata`, `rdata`. It has no reset.

## Test plan
- Write 32'h0000_0004 to addr 0, then read addr 0 with `WAIT_STATES`=2. Expect:
  - each ack high after E4;
  - read returns 32'h0000_0004 with `mem_error`=0;
  - `wr_count`=1, `rd_count`=1.
- Master-style loop of 8 write/read pairs at addr 0,4,…,28 with data 4,8,…,32. Expect:
  - every read matches its write;
  - no double ack while the request is held;
  - both counters end at 8.
- Read addr 32'h0000_0002, then read addr 32'h0000_1000 (`ADDR_WIDTH`=10). Expect `mem_error`=1 on both acks, `mem_read_data`=0, and counters unchanged.
- `mem_read` and `mem_write` high together with data 32'hDEAD_BEEF at addr 8. Expect:
  - error ack;
  - a later read of addr 8 returns the prior contents.
- Assert `reset` during WAIT of a write to addr 12. Expect:
  - `mem_ack` never pulses;
  - a later read of addr 12 returns the old value;
  - counters read 0.
- Preload `wr_count` to 16'hFFFE via 65534 writes (or force in the bench), then do 3 more writes. Expect `wr_count` holds at 16'hFFFF.
